// File: rtl/motor_drive_ctrl_if.sv
// Steering command in, wheel PWM / H-bridge pins and status out.
interface motor_drive_ctrl_if;
    logic [1:0] state;
    logic       left_pwm;
    logic       right_pwm;
    logic [1:0] left_dir;
    logic [1:0] right_dir;
    logic [1:0] cmd;
    logic       moving;

    modport master (
        output state,
        input  left_pwm,
        input  right_pwm,
        input  left_dir,
        input  right_dir,
        input  cmd,
        input  moving
    );

    modport slave (
        input  state,
        output left_pwm,
        output right_pwm,
        output left_dir,
        output right_dir,
        output cmd,
        output moving
    );
endinterface

// File: rtl/motor_drive_ctrl.sv
// Two-wheel motor drive: command debounce, soft-start ramps and
// period-aligned PWM with direction pins.
module motor_drive_ctrl #(
    parameter int DUTY_W        = 8,
    parameter int FWD_DUTY      = 200,
    parameter int TURN_OUTER    = 200,
    parameter int TURN_INNER    = 60,
    parameter int RAMP_STEP     = 8,
    parameter int STABLE_CYCLES = 4
) (
    input logic              clk,
    input logic              reset,
    motor_drive_ctrl_if.slave bus
);
    localparam int CW = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CW-1:0] STAB_MAX = CW'(STABLE_CYCLES - 1);
    localparam logic [DUTY_W:0] STEP = (DUTY_W + 1)'(RAMP_STEP);
    localparam logic [DUTY_W-1:0] D_FWD = DUTY_W'(FWD_DUTY);
    localparam logic [DUTY_W-1:0] D_OUT = DUTY_W'(TURN_OUTER);
    localparam logic [DUTY_W-1:0] D_INN = DUTY_W'(TURN_INNER);

    typedef enum logic [1:0] {
        STOP  = 2'b00,
        LEFT  = 2'b01,
        RIGHT = 2'b10,
        FWD   = 2'b11
    } cmd_e;

    cmd_e              cmd_q, cmd_d;
    logic [1:0]        cand_q, cand_d;
    logic [CW-1:0]     stab_q, stab_d;
    logic [DUTY_W-1:0] cnt_q, cnt_d;
    logic [DUTY_W-1:0] ld_q, ld_d;
    logic [DUTY_W-1:0] rd_q, rd_d;
    logic              lpwm_q, lpwm_d;
    logic              rpwm_q, rpwm_d;
    logic [1:0]        ldir_q, ldir_d;
    logic [1:0]        rdir_q, rdir_d;
    logic              mov_q, mov_d;
    logic [DUTY_W-1:0] ltgt, rtgt;
    logic              wrap;

    // Move cur toward tgt by at most STEP; extra bit keeps it overflow-free.
    function automatic logic [DUTY_W-1:0] ramp(
        input logic [DUTY_W-1:0] cur,
        input logic [DUTY_W-1:0] tgt
    );
        logic [DUTY_W:0] c, t;
        c = {1'b0, cur};
        t = {1'b0, tgt};
        if (t > c) begin
            ramp = (t - c > STEP) ? DUTY_W'(c + STEP) : tgt;
        end else begin
            ramp = (c - t > STEP) ? DUTY_W'(c - STEP) : tgt;
        end
    endfunction

    // A code is accepted once it has been sampled STABLE_CYCLES times in a row.
    always_comb begin
        cand_d = bus.state;
        stab_d = stab_q;
        cmd_d  = cmd_q;
        if (bus.state != cand_q) begin
            stab_d = '0;
        end else if (stab_q != STAB_MAX) begin
            stab_d = stab_q + CW'(1);
        end
        if (stab_q == STAB_MAX) begin
            cmd_d = cmd_e'(cand_q);
        end
    end

    always_comb begin
        ltgt = '0;
        rtgt = '0;
        unique case (cmd_q)
            STOP: begin
                ltgt = '0;
                rtgt = '0;
            end
            LEFT: begin
                ltgt = D_INN;
                rtgt = D_OUT;
            end
            RIGHT: begin
                ltgt = D_OUT;
                rtgt = D_INN;
            end
            FWD: begin
                ltgt = D_FWD;
                rtgt = D_FWD;
            end
        endcase
    end

    always_comb begin
        wrap   = &cnt_q;
        cnt_d  = cnt_q + DUTY_W'(1);
        ld_d   = wrap ? ramp(ld_q, ltgt) : ld_q;
        rd_d   = wrap ? ramp(rd_q, rtgt) : rd_q;
        lpwm_d = cnt_d < ld_d;
        rpwm_d = cnt_d < rd_d;
        ldir_d = (ld_d != '0) ? 2'b10 : 2'b00;
        rdir_d = (rd_d != '0) ? 2'b10 : 2'b00;
        mov_d  = (ld_d != '0) || (rd_d != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_q  <= STOP;
            cand_q <= '0;
            stab_q <= '0;
            cnt_q  <= '0;
            ld_q   <= '0;
            rd_q   <= '0;
            lpwm_q <= 1'b0;
            rpwm_q <= 1'b0;
            ldir_q <= 2'b00;
            rdir_q <= 2'b00;
            mov_q  <= 1'b0;
        end else begin
            cmd_q  <= cmd_d;
            cand_q <= cand_d;
            stab_q <= stab_d;
            cnt_q  <= cnt_d;
            ld_q   <= ld_d;
            rd_q   <= rd_d;
            lpwm_q <= lpwm_d;
            rpwm_q <= rpwm_d;
            ldir_q <= ldir_d;
            rdir_q <= rdir_d;
            mov_q  <= mov_d;
        end
    end

    assign bus.left_pwm  = lpwm_q;
    assign bus.right_pwm = rpwm_q;
    assign bus.left_dir  = ldir_q;
    assign bus.right_dir = rdir_q;
    assign bus.cmd       = cmd_q;
    assign bus.moving    = mov_q;
endmodule

// File: tb/tb_motor_drive_ctrl.sv
// Bench for motor_drive_ctrl: per-cycle model compare plus
// hand-computed duty, latency and reset checks.
module tb_motor_drive_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    motor_drive_ctrl_if bus ();

    motor_drive_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [8:0] outs();
        return {bus.left_pwm, bus.right_pwm, bus.left_dir,
                bus.right_dir, bus.cmd, bus.moving};
    endfunction

    // Reference model: duties per wheel, period position, sample history.
    int m_cnt, m_ld, m_rd, m_cmd;
    int hist [4];
    int nl, nr, nc;
    bit same;

    function automatic int tgt_l(input int c);
        case (c)
            1: return 60;
            2: return 200;
            3: return 200;
            default: return 0;
        endcase
    endfunction

    function automatic int tgt_r(input int c);
        case (c)
            1: return 200;
            2: return 60;
            3: return 200;
            default: return 0;
        endcase
    endfunction

    function automatic int step(input int cur, input int tgt);
        if (cur < tgt) return (tgt - cur > 8) ? cur + 8 : tgt;
        return (cur - tgt > 8) ? cur - 8 : tgt;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cnt <= 0;
            m_ld  <= 0;
            m_rd  <= 0;
            m_cmd <= 0;
            hist  <= '{0, -1, -1, -1};
        end else begin
            nl = m_ld;
            nr = m_rd;
            nc = m_cmd;
            if (m_cnt == 255) begin
                nl = step(m_ld, tgt_l(m_cmd));
                nr = step(m_rd, tgt_r(m_cmd));
            end
            same = (hist[0] >= 0);
            for (int i = 1; i < 4; i++)
                if (hist[i] != hist[0]) same = 0;
            if (same) nc = hist[0];
            m_ld  <= nl;
            m_rd  <= nr;
            m_cmd <= nc;
            m_cnt <= (m_cnt + 1) % 256;
            hist  <= '{int'(bus.state), hist[0], hist[1], hist[2]};
        end
    end

    always @(negedge clk) begin
        logic [8:0] e;
        if (reset) begin
            e = {m_cnt < m_ld, m_cnt < m_rd,
                 (m_ld > 0) ? 2'b10 : 2'b00,
                 (m_rd > 0) ? 2'b10 : 2'b00,
                 2'(m_cmd), (m_ld + m_rd) > 0};
            chk("cycle", 32'(outs()), 32'(e));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic count_hi(input int n, output int l, output int r);
        l = 0;
        r = 0;
        repeat (n) begin
            @(negedge clk);
            l += int'(bus.left_pwm);
            r += int'(bus.right_pwm);
        end
    endtask

    initial begin
        int k, l, r;
        bit ok;
        bus.state = 2'b00;
        #3 reset = 1'b0;
        #20 chk("reset_outputs", 32'(outs()), 0);

        // 1: idle in STOP
        @(negedge clk);
        #2 reset = 1'b1;
        cyc(1000);
        chk("idle_outputs", 32'(outs()), 0);

        // 2: forward from STOP
        @(negedge clk);
        bus.state = 2'b11;
        k = 0;
        ok = 0;
        repeat (20) begin
            @(negedge clk);
            k++;
            if (bus.cmd == 2'b11) begin
                ok = 1;
                break;
            end
        end
        chk("cmd_accept_seen", 32'(ok), 1);
        chk("cmd_accept_latency", k, 5);
        cyc(26 * 256);
        chk("model_fwd_duty", m_ld, 200);
        count_hi(256, l, r);
        chk("fwd_left_high", l, 200);
        chk("fwd_right_high", r, 200);
        chk("fwd_dirs", {bus.left_dir, bus.right_dir}, 4'b1010);

        // 3: short glitch rejected
        bus.state = 2'b01;
        cyc(3);
        bus.state = 2'b11;
        cyc(300);
        chk("glitch_cmd", 32'(bus.cmd), 3);
        count_hi(256, l, r);
        chk("glitch_left_high", l, 200);
        chk("glitch_right_high", r, 200);

        // 4: left turn, then right turn
        bus.state = 2'b01;
        cyc(19 * 256);
        chk("left_cmd", 32'(bus.cmd), 1);
        count_hi(256, l, r);
        chk("left_turn_l", l, 60);
        chk("left_turn_r", r, 200);
        bus.state = 2'b10;
        cyc(19 * 256);
        count_hi(256, l, r);
        chk("right_turn_l", l, 200);
        chk("right_turn_r", r, 60);

        // 5: soft stop from full forward
        bus.state = 2'b11;
        cyc(19 * 256);
        count_hi(256, l, r);
        chk("refwd_l", l, 200);
        bus.state = 2'b00;
        ok = 0;
        repeat (30 * 256) begin
            @(negedge clk);
            if (!bus.moving) begin
                ok = 1;
                break;
            end
        end
        chk("stop_reached", 32'(ok), 1);
        chk("stop_dirs", {bus.left_dir, bus.right_dir}, 0);
        count_hi(256, l, r);
        chk("stop_high", l + r, 0);

        // 6: reset mid-ramp, restart from zero
        bus.state = 2'b11;
        ok = 0;
        repeat (20 * 256) begin
            @(negedge clk);
            if (m_ld == 96) begin
                ok = 1;
                break;
            end
        end
        chk("ramp_to_96", 32'(ok), 1);
        cyc(100);
        chk("pre_reset_moving", 32'(bus.moving), 1);
        #2 reset = 1'b0;
        #1 chk("async_reset_outputs", 32'(outs()), 0);
        @(negedge clk);
        #2 reset = 1'b1;
        count_hi(255, l, r);
        chk("restart_first_period", l + r, 0);
        count_hi(256, l, r);
        chk("restart_left_high", l, 8);
        chk("restart_right_high", r, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
